// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write path.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic [RF_ADDR_W-1:0] REG_ZERO = {RF_ADDR_W{1'b0}};

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_wr_arbiter_sva.sv
// Protocol checks on the pipeline and MD interfaces of the write arbiter.
module regfile_wr_arbiter_sva #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic              clk,
  input logic              rst,
  input logic              wb_hold,
  input logic              wb_we,
  input logic              md_valid,
  input logic              md_ready,
  input logic [ADDR_W-1:0] md_addr,
  input logic [DATA_W-1:0] md_data
);

  a_hold_blocks_wb: assert property (@(posedge clk) disable iff (rst)
    wb_hold |-> !wb_we);

  a_hold_single: assert property (@(posedge clk) disable iff (rst)
    wb_hold |=> !wb_hold);

  a_md_stable: assert property (@(posedge clk) disable iff (rst)
    (md_valid && !md_ready) |=> (md_valid && $stable(md_addr) && $stable(md_data)));

endmodule

// File: rtl/regfile_wr_buf.sv
// Circular buffer of pending MD register writes with per-entry valid bits,
// address-matched kill and source-register pending lookup.
module regfile_wr_buf
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  rf_wr_t               push_ent,
  input  logic                 pop,
  input  logic                 kill,
  input  logic [RF_ADDR_W-1:0] kill_addr,
  input  logic [RF_ADDR_W-1:0] chk_rs,
  input  logic [RF_ADDR_W-1:0] chk_rt,
  output logic                 pend_rs,
  output logic                 pend_rt,
  output rf_wr_t               head,
  output logic                 head_valid,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rf_wr_t           ent_r [DEPTH];
  logic [DEPTH-1:0] vld_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_s;
  logic             pop_s;

  assign full    = (cnt_r == CNT_W'(DEPTH));
  assign empty   = (cnt_r == {CNT_W{1'b0}});
  assign count   = cnt_r;
  assign push_s  = push && !full;
  assign pop_s   = pop && !empty;

  assign head       = ent_r[rd_ptr_r];
  assign head_valid = vld_r[rd_ptr_r] && !empty;

  // Storage, valid bits and pointers; kill only touches entries already held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      vld_r    <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && vld_r[i] && (ent_r[i].addr == kill_addr)) begin
          vld_r[i] <= 1'b0;
        end
      end
      if (pop_s) begin
        vld_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r        <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s) begin
        ent_r[wr_ptr_r] <= push_ent;
        vld_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Pending lookup over live entries; register zero is never pending
  always_comb begin
    pend_rs = 1'b0;
    pend_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_rs = pend_rs | (vld_r[i] && (ent_r[i].addr == chk_rs));
      pend_rt = pend_rt | (vld_r[i] && (ent_r[i].addr == chk_rt));
    end
    pend_rs = pend_rs && (chk_rs != REG_ZERO);
    pend_rt = pend_rt && (chk_rt != REG_ZERO);
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between in-order writeback
// and buffered multiply/divide results, with starvation hold and hazard hints.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              wb_hold,
  input  logic [ADDR_W-1:0] chk_rs,
  input  logic [ADDR_W-1:0] chk_rt,
  output logic              pend_rs,
  output logic              pend_rt
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = $clog2(STARVE_MAX + 1);

  logic             wb_act_s;
  logic             pop_s;
  logic             push_s;
  logic             full_s;
  logic             empty_s;
  logic [CNT_W-1:0] count_s;
  rf_wr_t           push_ent_s;
  rf_wr_t           head_s;
  logic             head_valid_s;
  logic [AGE_W-1:0] age_r;
  logic [AGE_W-1:0] age_nxt_s;
  logic             hold_set_s;
  logic             wb_hold_r;

  // A WB write to register zero is treated as an idle WB slot
  assign wb_act_s = !rst && wb_we && (wb_addr != REG_ZERO);
  assign pop_s    = !wb_act_s && !empty_s;
  assign md_ready = !rst && !full_s;
  assign push_s   = md_valid && md_ready && (md_addr != REG_ZERO);

  assign push_ent_s.addr = md_addr;
  assign push_ent_s.data = md_data;

  regfile_wr_buf #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_ent   (push_ent_s),
    .pop        (pop_s),
    .kill       (wb_act_s),
    .kill_addr  (wb_addr),
    .chk_rs     (chk_rs),
    .chk_rt     (chk_rt),
    .pend_rs    (pend_rs),
    .pend_rt    (pend_rt),
    .head       (head_s),
    .head_valid (head_valid_s),
    .full       (full_s),
    .empty      (empty_s),
    .count      (count_s)
  );

  // Write-port grant: WB first, otherwise drain the head (killed head writes nothing)
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = {ADDR_W{1'b0}};
    rf_data = {DATA_W{1'b0}};
    if (wb_act_s) begin
      rf_we   = 1'b1;
      rf_addr = wb_addr;
      rf_data = wb_data;
    end else if (pop_s) begin
      rf_we   = head_valid_s;
      rf_addr = head_s.addr;
      rf_data = head_s.data;
    end else begin
      rf_we   = 1'b0;
      rf_addr = {ADDR_W{1'b0}};
      rf_data = {DATA_W{1'b0}};
    end
  end

  // Head age, saturating; any pop or an empty buffer restarts it
  always_comb begin
    age_nxt_s = age_r;
    if (pop_s || empty_s) begin
      age_nxt_s = {AGE_W{1'b0}};
    end else if (age_r < AGE_W'(STARVE_MAX)) begin
      age_nxt_s = age_r + AGE_W'(1);
    end else begin
      age_nxt_s = age_r;
    end
  end

  // One hold pulse per starvation episode; the hold cycle itself drains the head
  assign hold_set_s = (age_r == AGE_W'(STARVE_MAX)) && !pop_s && !empty_s && !wb_hold_r;

  // Age and hold registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_r     <= {AGE_W{1'b0}};
      wb_hold_r <= 1'b0;
    end else begin
      age_r     <= age_nxt_s;
      wb_hold_r <= hold_set_s;
    end
  end

  assign wb_hold = wb_hold_r;

  regfile_wr_arbiter_sva #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sva (
    .clk      (clk),
    .rst      (rst),
    .wb_hold  (wb_hold_r),
    .wb_we    (wb_we),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_addr  (md_addr),
    .md_data  (md_data)
  );

endmodule
